i2c_master_arbiter: RTL

- Shares one i2c_master between NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's address, rw bit and write byte, then drives them to the master's addr, data_in, rw and enable inputs.
- Tracks the master's ready handshake and returns the read byte, with a one-cycle done pulse, to the granted requester.
- Sits between bus-side peripherals (sensor pollers, config loaders) and the single I2C master instance.

---
 rtl/i2c_master_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of a single i2c_master between
// NUM_REQ requesters. The winner's address/rw/write byte are latched onto the
// master inputs; completion is reported with a one-cycle done pulse and the
// read byte on rdata.
// Optional build macro: I2C_ARB_TIMEOUT_EN adds a LAUNCH+BUSY watchdog that
// aborts a stuck transaction after TIMEOUT_CYCLES clocks and reports err.
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             rdata,
  output logic                   err,
  output logic                   busy,
  output logic [6:0]             m_addr,
  output logic [7:0]             m_data_in,
  output logic                   m_rw,
  output logic                   m_enable,
  input  logic                   m_ready,
  input  logic [7:0]             m_read_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr;          // first requester searched on the next grant
  logic [IW-1:0] idx;          // requester currently owning the master
  logic [IW-1:0] sel;          // round-robin winner among current requests
  logic          rdy_meta, rdy_s;
  logic          timeout_hit;

  // Two-flop synchronizer for the master's ready; an idle master reports ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_meta <= 1'b1;
      rdy_s    <= 1'b1;
    end else begin
      rdy_meta <= m_ready;
      rdy_s    <= rdy_meta;
    end
  end

  // Round-robin search: walk offsets from the far end down so the requester
  // closest to (at or after) the pointer is the one that sticks.
  always_comb begin : rr_pick
    int cand;
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no stale value (and no latch) can survive a path.
    sel  = ptr;
    cand = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (req[cand]) sel = IW'(cand);
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // Watchdog: cleared on the grant that enters LAUNCH, counts LAUNCH+BUSY cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE && |req) begin
      tmo_cnt <= '0;
    end else if (state == LAUNCH || state == BUSY) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Abort on the edge where the counter reaches TIMEOUT_CYCLES.
  assign timeout_hit = (state == LAUNCH || state == BUSY) &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Error flag: set by an abort, cleared by the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == IDLE && |req) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = LAUNCH;
      LAUNCH:  if (timeout_hit) state_nxt = DONE;
               else if (!rdy_s) state_nxt = BUSY;
      BUSY:    if (timeout_hit || rdy_s) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, master-side latches, completion pulse and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is sequential state and uses non-blocking '<='
    // so all of them update together from the same pre-edge values.
    if (!rst_n) begin
      gnt       <= '0;
      done      <= '0;
      idx       <= '0;
      ptr       <= '0;
      rdata     <= '0;
      m_addr    <= '0;
      m_data_in <= '0;
      m_rw      <= 1'b0;
      m_enable  <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
            idx       <= sel;
            m_addr    <= req_addr[int'(sel)*7 +: 7];
            m_data_in <= req_wdata[int'(sel)*8 +: 8];
            m_rw      <= req_rw[sel];
            m_enable  <= 1'b1;
          end
        end
        LAUNCH: begin
          if (timeout_hit) begin
            m_enable <= 1'b0;
            rdata    <= '0;
            done     <= gnt;
            gnt      <= '0;
          end else if (!rdy_s) begin
            // Master has started; drop enable so it ends with STOP, not a chain.
            m_enable <= 1'b0;
          end
        end
        BUSY: begin
          if (timeout_hit) begin
            rdata <= '0;
            done  <= gnt;
            gnt   <= '0;
          end else if (rdy_s) begin
            if (m_rw) rdata <= m_read_data;
            done <= gnt;
            gnt  <= '0;
          end
        end
        DONE: begin
          ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
